i2c_target_regs: RTL and testbench

//  Parametrised I2C target (slave) bridging an I2C bus to an on-chip 8-bit register bank.

---
 rtl/i2c_target_regs.sv | 265 ++++++++++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regs.sv
// I2C target bridging the bus to an 8-bit local register bank.
// The bus side covers the pointer byte, burst writes/reads with pointer auto-increment,
// repeated START handling and input glitch filtering. Open-drain SDA: sda_oe_o=1 pulls low.
module i2c_target_regs #(
  parameter logic [6:0]  DEV_ADDR    = 7'h42,
  parameter int unsigned PTR_W       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe_o,
  output logic [PTR_W-1:0] reg_addr_o,
  output logic [7:0]       reg_wdata_o,
  output logic             reg_we_o,
  input  logic [7:0]       reg_rdata_i,
  output logic             reg_re_o,
  output logic             busy_o
);

  localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN - 1);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ACK_A,
    ST_PTR,
    ST_ACK_P,
    ST_WR,
    ST_ACK_W,
    ST_RD,
    ST_ACK_R,
    ST_WAIT
  } state_e;

  // Index 0 carries SCL, index 1 carries SDA through the input path.
  logic [1:0]             raw;
  logic [SYNC_STAGES-1:0] sync_q [2];
  logic [SYNC_STAGES-1:0] sync_d [2];
  logic [CNT_W-1:0]       cnt_q  [2];
  logic [CNT_W-1:0]       cnt_d  [2];
  logic [1:0]             flt_q, flt_d;
  logic [1:0]             prev_q, prev_d;

  logic scl_rise, scl_fall, start_det, stop_det;

  state_e           state_q, state_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] ptr_load;
  logic [7:0]       wdata_q, wdata_d;
  logic             we_q, we_d;
  logic             re_q, re_d;
  logic             oe_q, oe_d;
  logic             busy_q, busy_d;
  logic             rw_q, rw_d;

  assign raw = {sda_i, scl_i};

  // Synchroniser shift and counter filter: level flips only after FILTER_LEN differing samples.
  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], raw[i]};
      flt_d[i]  = flt_q[i];
      cnt_d[i]  = '0;
      if (sync_q[i][SYNC_STAGES-1] != flt_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          flt_d[i] = sync_q[i][SYNC_STAGES-1];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    prev_d = flt_q;
  end

  // Input path registers; preset high so reset looks like an idle bus.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < 2; i++) begin
        sync_q[i] <= '1;
        cnt_q[i]  <= '0;
      end
      flt_q  <= '1;
      prev_q <= '1;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        sync_q[i] <= sync_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      flt_q  <= flt_d;
      prev_q <= prev_d;
    end
  end

  // Bus events from the filtered levels; START/STOP need SCL steady high.
  always_comb begin
    scl_rise  = flt_q[0] & ~prev_q[0];
    scl_fall  = ~flt_q[0] & prev_q[0];
    start_det = ~flt_q[1] & prev_q[1] & flt_q[0] & prev_q[0];
    stop_det  = flt_q[1] & ~prev_q[1] & flt_q[0] & prev_q[0];
  end

  // Pointer byte zero-extended or truncated to PTR_W bits.
  always_comb begin
    for (int unsigned i = 0; i < PTR_W; i++) begin
      ptr_load[i] = (i < 8) ? shreg_q[i[2:0]] : 1'b0;
    end
  end

  // Protocol FSM: samples on SCL rise, changes SDA only on SCL fall.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    ptr_d     = ptr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    re_d      = 1'b0;
    oe_d      = oe_q;
    busy_d    = busy_q;
    rw_d      = rw_q;

    // Read data is captured the cycle after the strobe, while reg_addr_o is stable.
    if (re_q) begin
      shreg_d = reg_rdata_i;
      oe_d    = ~reg_rdata_i[7];
    end

    if (start_det) begin
      state_d   = ST_ADDR;
      bit_cnt_d = '0;
      oe_d      = 1'b0;
    end else if (stop_det) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      oe_d      = 1'b0;
      busy_d    = 1'b0;
    end else if (scl_rise) begin
      unique case (state_q)
        ST_ADDR, ST_PTR, ST_WR: begin
          shreg_d   = {shreg_q[6:0], flt_q[1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
        ST_RD: bit_cnt_d = bit_cnt_q + 1'b1;
        // Pointer advances on the master ACK so the next fall reads the new address.
        ST_ACK_R: begin
          if (!flt_q[1]) begin
            ptr_d = ptr_q + 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      unique case (state_q)
        ST_ADDR: begin
          if (bit_cnt_q == 4'd8) begin
            if (shreg_q[7:1] == DEV_ADDR) begin
              state_d = ST_ACK_A;
              oe_d    = 1'b1;
              busy_d  = 1'b1;
              rw_d    = shreg_q[0];
            end else begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
            end
          end
        end
        ST_ACK_A: begin
          oe_d      = 1'b0;
          bit_cnt_d = '0;
          if (rw_q) begin
            state_d = ST_RD;
            re_d    = 1'b1;
          end else begin
            state_d = ST_PTR;
          end
        end
        ST_PTR: begin
          if (bit_cnt_q == 4'd8) begin
            ptr_d   = ptr_load;
            oe_d    = 1'b1;
            state_d = ST_ACK_P;
          end
        end
        ST_ACK_P: begin
          oe_d      = 1'b0;
          bit_cnt_d = '0;
          state_d   = ST_WR;
        end
        ST_WR: begin
          if (bit_cnt_q == 4'd8) begin
            we_d    = 1'b1;
            wdata_d = shreg_q;
            oe_d    = 1'b1;
            state_d = ST_ACK_W;
          end
        end
        ST_ACK_W: begin
          ptr_d     = ptr_q + 1'b1;
          oe_d      = 1'b0;
          bit_cnt_d = '0;
          state_d   = ST_WR;
        end
        ST_RD: begin
          if (bit_cnt_q == 4'd8) begin
            oe_d    = 1'b0;
            state_d = ST_ACK_R;
          end else begin
            shreg_d = {shreg_q[6:0], 1'b0};
            oe_d    = ~shreg_q[6];
          end
        end
        // Only an ACKed byte stays in ACK_R until the fall.
        ST_ACK_R: begin
          bit_cnt_d = '0;
          re_d      = 1'b1;
          state_d   = ST_RD;
        end
        default: ;
      endcase
    end
  end

  // Protocol state registers; async reset also releases SDA immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      ptr_q     <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      rw_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      ptr_q     <= ptr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      re_q      <= re_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
      rw_q      <= rw_d;
    end
  end

  assign sda_oe_o    = oe_q;
  assign reg_addr_o  = ptr_q;
  assign reg_wdata_o = wdata_q;
  assign reg_we_o    = we_q;
  assign reg_re_o    = re_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: two targets share one open-drain bus
// (0x42 with 8-bit pointer, 0x43 with 4-bit pointer) driven by a bit-banged master.
module tb_i2c_target_regs;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       scl_m, sda_m;
  logic       sda_bus;
  logic       oe0, oe1;
  logic [7:0] addr0, wdata0, rdata0;
  logic       we0, re0, busy0;
  logic [3:0] addr1;
  logic [7:0] wdata1, rdata1;
  logic       we1, re1, busy1;
  logic [7:0] regs [256];

  assign sda_bus = sda_m & ~oe0 & ~oe1;
  assign rdata0  = regs[addr0];
  assign rdata1  = 8'h00;

  i2c_target_regs u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .scl_i(scl_m), .sda_i(sda_bus), .sda_oe_o(oe0),
    .reg_addr_o(addr0), .reg_wdata_o(wdata0), .reg_we_o(we0), .reg_rdata_i(rdata0),
    .reg_re_o(re0), .busy_o(busy0)
  );

  i2c_target_regs #(.DEV_ADDR(7'h43), .PTR_W(4)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .scl_i(scl_m), .sda_i(sda_bus), .sda_oe_o(oe1),
    .reg_addr_o(addr1), .reg_wdata_o(wdata1), .reg_we_o(we1), .reg_rdata_i(rdata1),
    .reg_re_o(re1), .busy_o(busy1)
  );

  // Activity monitors, sampled on the inactive clock edge.
  int unsigned oe0_cyc = 0, oe1_cyc = 0, busy0_cyc = 0, busy1_cyc = 0, re0_cnt = 0, re1_cnt = 0;
  logic [15:0] wlog0[$];
  logic [15:0] wlog1[$];
  always @(negedge clk) begin
    if (oe0) oe0_cyc++;
    if (oe1) oe1_cyc++;
    if (busy0) busy0_cyc++;
    if (busy1) busy1_cyc++;
    if (re0) re0_cnt++;
    if (re1) re1_cnt++;
    if (we0) wlog0.push_back({addr0, wdata0});
    if (we1) wlog1.push_back({4'h0, addr1, wdata1});
  end

  int unsigned n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic q();
    repeat (8) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; q(); scl_m = 1'b1; q(); sda_m = 1'b0; q(); scl_m = 1'b0; q();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; q(); scl_m = 1'b1; q(); sda_m = 1'b1; q();
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    sda_m = b; q(); scl_m = 1'b1; q();
    if (glitch) begin
      scl_m = 1'b0;
      repeat (2) @(negedge clk);
      scl_m = 1'b1;
    end
    q(); scl_m = 1'b0; q();
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1; q(); scl_m = 1'b1; q(); b = sda_bus; q(); scl_m = 1'b0; q();
  endtask

  task automatic send_byte(input logic [7:0] d, input int glitch_at, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i], i == glitch_at);
    recv_bit(ack);
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic ack_bit);
    logic b;
    d = '0;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d = {d[6:0], b};
    end
    send_bit(ack_bit, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic        ack;
    logic [7:0]  rd;
    int unsigned base0, base1, snap_oe0, snap_oe1, snap_busy0, snap_busy1, snap_re0;

    for (int i = 0; i < 256; i++) regs[i] = 8'(i);
    regs[8'h20] = 8'h3C;
    regs[8'h21] = 8'hC3;

    rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_oe", oe0, 1'b0);
    check("rst_addr", addr0, 8'h00);
    check("rst_wdata", wdata0, 8'h00);
    check("rst_we", we0, 1'b0);
    check("rst_re", re0, 1'b0);
    check("rst_busy", busy0, 1'b0);
    rst_n = 1'b1;
    q();

    // T1: burst write from pointer 0x10.
    base0 = wlog0.size();
    bus_start();
    send_byte(8'h84, -1, ack); check("t1_ack_addr", ack, 1'b0);
    check("t1_busy", busy0, 1'b1);
    send_byte(8'h10, -1, ack); check("t1_ack_ptr", ack, 1'b0);
    send_byte(8'hA5, -1, ack); check("t1_ack_d0", ack, 1'b0);
    send_byte(8'h5A, -1, ack); check("t1_ack_d1", ack, 1'b0);
    bus_stop(); q();
    check("t1_nwr", wlog0.size() - base0, 2);
    if (wlog0.size() >= base0 + 2) begin
      check("t1_wr0", wlog0[base0], 16'h10A5);
      check("t1_wr1", wlog0[base0+1], 16'h115A);
    end
    check("t1_ptr", addr0, 8'h12);
    check("t1_busy_end", busy0, 1'b0);

    // T2: combined write-pointer / repeated START / read.
    snap_re0 = re0_cnt;
    bus_start();
    send_byte(8'h84, -1, ack); check("t2_ack_waddr", ack, 1'b0);
    send_byte(8'h20, -1, ack); check("t2_ack_ptr", ack, 1'b0);
    bus_start();
    send_byte(8'h85, -1, ack); check("t2_ack_raddr", ack, 1'b0);
    recv_byte(rd, 1'b0); check("t2_rd0", rd, 8'h3C);
    recv_byte(rd, 1'b1); check("t2_rd1", rd, 8'hC3);
    check("t2_re_cnt", re0_cnt - snap_re0, 2);
    check("t2_ptr", addr0, 8'h21);
    snap_oe0 = oe0_cyc;
    send_byte(8'h00, -1, ack);
    check("t2_wait_oe", oe0_cyc - snap_oe0, 0);
    check("t2_wait_busy", busy0, 1'b1);
    bus_stop(); q();
    check("t2_busy_end", busy0, 1'b0);

    // T3: nobody answers 0x48.
    snap_oe0 = oe0_cyc; snap_oe1 = oe1_cyc; snap_busy0 = busy0_cyc; snap_busy1 = busy1_cyc;
    bus_start();
    send_byte(8'h90, -1, ack); check("t3_nack", ack, 1'b1);
    send_byte(8'h00, -1, ack);
    bus_stop(); q();
    check("t3_oe0", oe0_cyc - snap_oe0, 0);
    check("t3_oe1", oe1_cyc - snap_oe1, 0);
    check("t3_busy0", busy0_cyc - snap_busy0, 0);
    check("t3_busy1", busy1_cyc - snap_busy1, 0);

    // T4: 4-bit pointer wraps from 0xF to 0x0 on the second target.
    base0 = wlog0.size(); base1 = wlog1.size(); snap_busy0 = busy0_cyc;
    bus_start();
    send_byte(8'h86, -1, ack); check("t4_ack_addr", ack, 1'b0);
    send_byte(8'h0F, -1, ack); check("t4_ack_ptr", ack, 1'b0);
    send_byte(8'h11, -1, ack);
    send_byte(8'h22, -1, ack); check("t4_ack_d1", ack, 1'b0);
    bus_stop(); q();
    check("t4_nwr", wlog1.size() - base1, 2);
    if (wlog1.size() >= base1 + 2) begin
      check("t4_wr0", wlog1[base1], 16'h0F11);
      check("t4_wr1", wlog1[base1+1], 16'h0022);
    end
    check("t4_ptr", addr1, 4'h1);
    check("t4_other_nwr", wlog0.size() - base0, 0);
    check("t4_other_busy", busy0_cyc - snap_busy0, 0);

    // T5: 2-cycle SCL low glitches inside high phases are filtered out.
    base0 = wlog0.size();
    bus_start();
    send_byte(8'h84, -1, ack);
    send_byte(8'h30, 0, ack); check("t5_ack_ptr", ack, 1'b0);
    send_byte(8'h96, 4, ack); check("t5_ack_d", ack, 1'b0);
    bus_stop(); q();
    check("t5_nwr", wlog0.size() - base0, 1);
    if (wlog0.size() >= base0 + 1) check("t5_wr", wlog0[base0], 16'h3096);
    check("t5_ptr", addr0, 8'h31);

    // T6a: STOP after four data bits aborts the byte.
    base0 = wlog0.size();
    bus_start();
    send_byte(8'h84, -1, ack);
    send_byte(8'h40, -1, ack);
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
    bus_stop(); q();
    check("t6_abort_nwr", wlog0.size() - base0, 0);
    check("t6_abort_ptr", addr0, 8'h40);
    check("t6_abort_busy", busy0, 1'b0);

    // T6b: reset while the address ACK is being driven.
    bus_start();
    for (int i = 7; i >= 0; i--) send_bit(1'(8'h84 >> i), 1'b0);
    sda_m = 1'b1; q(); scl_m = 1'b1; q();
    check("t6_ack_driven", oe0, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_oe", oe0, 1'b0);
    check("t6_rst_sda", sda_bus, 1'b1);
    check("t6_rst_ptr", addr0, 8'h00);
    check("t6_rst_busy", busy0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    q();

    // Target recovers after reset.
    base0 = wlog0.size();
    bus_start();
    send_byte(8'h84, -1, ack); check("t6_post_ack", ack, 1'b0);
    send_byte(8'h05, -1, ack);
    send_byte(8'h77, -1, ack);
    bus_stop(); q();
    check("t6_post_nwr", wlog0.size() - base0, 1);
    if (wlog0.size() >= base0 + 1) check("t6_post_wr", wlog0[base0], 16'h0577);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
